// File: rtl/pcw_loader_pkg.sv
// Shared types and constants for the PCW boot-image loader.
package pcw_loader_pkg;

   localparam int unsigned ADDR_W       = 16;
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned LAT_W        = 2;
   localparam int unsigned BOOT_ROM_LEN = 276;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WRITE = 2'd2,
      EXEC  = 2'd3
   } state_e;

   // One pending write into the memory download port.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } mem_wr_t;

endpackage

// File: rtl/boot_loader_seq_if.sv
// Boot ROM read port plus memory download port; the sequencer is the master.
interface boot_loader_seq_if;
   import pcw_loader_pkg::*;

   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wait;

   modport master (
      output rom_addr, mem_wr, mem_addr, mem_data,
      input  rom_data, mem_wait
   );

   modport slave (
      input  rom_addr, mem_wr, mem_addr, mem_data,
      output rom_data, mem_wait
   );

endinterface

// File: rtl/boot_loader_seq.sv
// Copies the boot ROM image into main memory after reset, then pulses execute.
module boot_loader_seq
   import pcw_loader_pkg::*;
#(
   parameter int unsigned       ROM_LEN   = BOOT_ROM_LEN,
   parameter int unsigned       ROM_LAT   = 1,
   parameter logic [ADDR_W-1:0] EXEC_ADDR = 16'h0000
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   boot_loader_seq_if.master bus,
   output logic              download,
   output logic              execute_enable,
   output logic [ADDR_W-1:0] execute_addr
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROM_LEN - 1);
   localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(ROM_LAT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   mem_wr_t           wr_q, wr_d;
   logic              mem_wr_q, mem_wr_d;
   logic              download_q, download_d;
   logic              exe_en_q, exe_en_d;
   logic [ADDR_W-1:0] exe_addr_q, exe_addr_d;

   // State, byte counter and registered outputs.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         lat_q      <= '0;
         rom_addr_q <= '0;
         wr_q       <= '0;
         mem_wr_q   <= 1'b0;
         download_q <= 1'b0;
         exe_en_q   <= 1'b0;
         exe_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lat_q      <= lat_d;
         rom_addr_q <= rom_addr_d;
         wr_q       <= wr_d;
         mem_wr_q   <= mem_wr_d;
         download_q <= download_d;
         exe_en_q   <= exe_en_d;
         exe_addr_q <= exe_addr_d;
      end
   end

   // Next state and next output values; an accept coincident with abort still counts as written.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lat_d      = lat_q;
      rom_addr_d = rom_addr_q;
      wr_d       = wr_q;
      mem_wr_d   = mem_wr_q;
      download_d = download_q;
      exe_en_d   = 1'b0;
      exe_addr_d = '0;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               cnt_d      = '0;
               lat_d      = '0;
               rom_addr_d = '0;
               download_d = 1'b1;
               state_d    = FETCH;
            end
         end

         FETCH: begin
            if (abort) begin
               mem_wr_d   = 1'b0;
               download_d = 1'b0;
               state_d    = IDLE;
            end else if (lat_q == LAT_LAST) begin
               wr_d.addr = cnt_q;
               wr_d.data = bus.rom_data;
               mem_wr_d  = 1'b1;
               state_d   = WRITE;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end

         WRITE: begin
            if (abort) begin
               mem_wr_d   = 1'b0;
               download_d = 1'b0;
               state_d    = IDLE;
            end else if (!bus.mem_wait) begin
               mem_wr_d = 1'b0;
               if (cnt_q == LAST_IDX) begin
                  exe_en_d   = 1'b1;
                  exe_addr_d = EXEC_ADDR;
                  download_d = 1'b0;
                  state_d    = EXEC;
               end else begin
                  cnt_d      = cnt_q + ADDR_W'(1);
                  rom_addr_d = cnt_q + ADDR_W'(1);
                  lat_d      = '0;
                  state_d    = FETCH;
               end
            end
         end

         EXEC: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.rom_addr   = rom_addr_q;
   assign bus.mem_wr     = mem_wr_q;
   assign bus.mem_addr   = wr_q.addr;
   assign bus.mem_data   = wr_q.data;
   assign download       = download_q;
   assign execute_enable = exe_en_q;
   assign execute_addr   = exe_addr_q;

endmodule

// File: tb/tb_boot_loader_seq.sv
// Bench for boot_loader_seq: scenario table on the full-size image, plus a slow-ROM short image.
module tb_boot_loader_seq;
   import pcw_loader_pkg::*;

   localparam int unsigned LEN_A  = BOOT_ROM_LEN;
   localparam int unsigned LAT_A  = 1;
   localparam int unsigned LEN_B  = 4;
   localparam int unsigned LAT_B  = 3;
   localparam logic [15:0] EXEC_A = 16'h0000;
   localparam logic [15:0] EXEC_B = 16'h0100;

   localparam int K_PLAIN = 0, K_ABORT = 1, K_RESET = 2, K_RESTART = 3,
                  K_ABORT_IDLE = 4, K_RESET_START = 5;
   localparam int S_NONE = 0, S_BYTE10 = 1, S_RANDOM = 2;

   typedef struct {
      int kind;
      int inj_byte;
      int stall_mode;
      int exp_writes;
      int exp_exec;
   } scen_t;

   logic        clk_sys;
   logic        reset;
   logic        start_a, abort_a, download_a, exe_en_a;
   logic [15:0] exe_addr_a;
   logic        start_b, abort_b, download_b, exe_en_b;
   logic [15:0] exe_addr_b;

   boot_loader_seq_if a_if ();
   boot_loader_seq_if b_if ();

   boot_loader_seq #(.ROM_LEN(LEN_A), .ROM_LAT(LAT_A), .EXEC_ADDR(EXEC_A)) u_dut_a (
      .clk_sys(clk_sys), .reset(reset), .start(start_a), .abort(abort_a), .bus(a_if),
      .download(download_a), .execute_enable(exe_en_a), .execute_addr(exe_addr_a));

   boot_loader_seq #(.ROM_LEN(LEN_B), .ROM_LAT(LAT_B), .EXEC_ADDR(EXEC_B)) u_dut_b (
      .clk_sys(clk_sys), .reset(reset), .start(start_b), .abort(abort_b), .bus(b_if),
      .download(download_b), .execute_enable(exe_en_b), .execute_addr(exe_addr_b));

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int unsigned cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // Boot ROM images: A answers within the cycle, B has two extra register stages.
   logic [7:0]  rom_a [LEN_A];
   logic [7:0]  rom_b [LEN_B];
   logic [15:0] b_d1, b_d2;

   function automatic logic [7:0] rd_a(input logic [15:0] a);
      return (int'(a) < int'(LEN_A)) ? rom_a[int'(a)] : 8'h00;
   endfunction

   function automatic logic [7:0] rd_b(input logic [15:0] a);
      return (int'(a) < int'(LEN_B)) ? rom_b[int'(a)] : 8'h00;
   endfunction

   assign a_if.rom_data = rd_a(a_if.rom_addr);
   always @(posedge clk_sys) begin
      b_d1 <= b_if.rom_addr;
      b_d2 <= b_d1;
   end
   assign b_if.rom_data = rd_b(b_d2);

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // Write and execute logs collected by the run loops.
   logic [15:0] acc_addr [$];
   logic [7:0]  acc_data [$];
   logic        acc_dl   [$];
   int unsigned acc_cyc  [$];
   int unsigned exe_cyc  [$];
   logic [15:0] exe_adr  [$];

   task automatic clear_logs();
      acc_addr.delete(); acc_data.delete(); acc_dl.delete(); acc_cyc.delete();
      exe_cyc.delete();  exe_adr.delete();
   endtask

   function automatic logic [63:0] idle_word_a();
      return 64'({a_if.mem_wr, a_if.mem_addr, a_if.mem_data, a_if.rom_addr,
                  download_a, exe_en_a, exe_addr_a});
   endfunction

   function automatic logic [63:0] idle_word_b();
      return 64'({b_if.mem_wr, b_if.mem_addr, b_if.mem_data, b_if.rom_addr,
                  download_b, exe_en_b, exe_addr_b});
   endfunction

   // Drive one scenario on instance A and compare the logs against the timing/content model.
   task automatic run_a(input int si, input scen_t s);
      int unsigned plan [LEN_A];
      int unsigned t_exp [LEN_A];
      int unsigned n_start, stall_left, quiet, t_acc;
      logic [15:0] prev_addr;
      logic [7:0]  prev_data;
      bit          prev_stall, inj_done, rst_chk, abort_chk, done;

      for (int k = 0; k < int'(LEN_A); k++) begin
         plan[k] = 0;
         if (s.stall_mode == S_RANDOM && $urandom_range(0, 9) < 3)
            plan[k] = $urandom_range(1, 3);
      end
      if (s.stall_mode == S_BYTE10) plan[10] = 5;
      clear_logs();

      @(negedge clk_sys);
      a_if.mem_wait = 1'b0;
      start_a = 1'b1;
      abort_a = (s.kind == K_ABORT_IDLE);
      reset   = (s.kind == K_RESET_START);
      rst_chk = (s.kind == K_RESET_START);
      n_start = cyc + 1;
      stall_left = plan[0];
      prev_stall = 0; inj_done = 0; abort_chk = 0; done = 0; quiet = 0;
      prev_addr = '0; prev_data = '0;

      for (int t = 0; t < 4000; t++) begin
         @(negedge clk_sys);
         start_a = 1'b0;
         abort_a = 1'b0;
         reset   = 1'b0;
         if (rst_chk) begin
            chk($sformatf("A%0d outputs after reset", si), idle_word_a(), 64'd0);
            rst_chk = 0;
         end
         if (abort_chk) begin
            chk($sformatf("A%0d wr/download after abort", si),
                64'({a_if.mem_wr, download_a}), 64'd0);
            abort_chk = 0;
         end
         if (a_if.mem_wr) begin
            if (prev_stall)
               chk($sformatf("A%0d stall hold", si), 64'({a_if.mem_addr, a_if.mem_data}),
                   64'({prev_addr, prev_data}));
            if (stall_left > 0) begin
               a_if.mem_wait = 1'b1;
               stall_left--;
               prev_stall = 1;
               prev_addr  = a_if.mem_addr;
               prev_data  = a_if.mem_data;
            end else begin
               a_if.mem_wait = 1'b0;
               prev_stall = 0;
               acc_addr.push_back(a_if.mem_addr);
               acc_data.push_back(a_if.mem_data);
               acc_dl.push_back(download_a);
               acc_cyc.push_back(cyc + 1);
               stall_left = (int'(a_if.mem_addr) + 1 < int'(LEN_A)) ?
                            plan[int'(a_if.mem_addr) + 1] : 0;
            end
            if (!inj_done && int'(a_if.mem_addr) == s.inj_byte) begin
               inj_done = 1;
               case (s.kind)
                  K_ABORT:   begin abort_a = 1'b1; abort_chk = 1; end
                  K_RESET:   begin reset   = 1'b1; rst_chk   = 1; end
                  K_RESTART: start_a = 1'b1;
                  default:   ;
               endcase
            end
         end else begin
            a_if.mem_wait = 1'($urandom_range(0, 1));
            prev_stall = 0;
         end
         if (exe_en_a) begin
            exe_cyc.push_back(cyc + 1);
            exe_adr.push_back(exe_addr_a);
         end
         if (!a_if.mem_wr && !download_a && !exe_en_a) quiet++;
         else quiet = 0;
         if (quiet >= 8) begin
            done = 1;
            break;
         end
      end
      a_if.mem_wait = 1'b0;
      if (!done) chk($sformatf("A%0d run timeout", si), 64'd1, 64'd0);

      // Byte k lands (ROM_LAT+1) cycles after the previous one, plus its stall cycles.
      t_acc = n_start;
      for (int k = 0; k < s.exp_writes; k++) begin
         t_acc += LAT_A + 1 + plan[k];
         t_exp[k] = t_acc;
      end
      chk($sformatf("A%0d write count", si), 64'(acc_addr.size()), 64'(s.exp_writes));
      for (int k = 0; k < int'(acc_addr.size()) && k < s.exp_writes; k++)
         chk($sformatf("A%0d byte %0d {addr,data,dl,cyc}", si, k),
             {7'd0, acc_addr[k], acc_data[k], acc_dl[k], acc_cyc[k]},
             {7'd0, 16'(k), rom_a[k], 1'b1, t_exp[k]});
      chk($sformatf("A%0d execute count", si), 64'(exe_cyc.size()), 64'(s.exp_exec));
      if (exe_cyc.size() > 0 && s.exp_exec == 1)
         chk($sformatf("A%0d execute {cyc,addr}", si), 64'({exe_cyc[0], exe_adr[0]}),
             64'({t_exp[s.exp_writes-1] + 1, EXEC_A}));
      chk($sformatf("A%0d idle after run", si),
          64'({download_a, exe_en_a, a_if.mem_wr, exe_addr_a}), 64'd0);
   endtask

   // Slow ROM, short image: writes 4 cycles apart, execute right after the last accept.
   task automatic run_b();
      int unsigned n_start;
      bit          done;
      clear_logs();
      done = 0;
      @(negedge clk_sys);
      start_b = 1'b1;
      n_start = cyc + 1;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk_sys);
         start_b = 1'b0;
         if (b_if.mem_wr) begin
            acc_addr.push_back(b_if.mem_addr);
            acc_data.push_back(b_if.mem_data);
            acc_dl.push_back(download_b);
            acc_cyc.push_back(cyc + 1);
         end
         if (exe_en_b) begin
            exe_cyc.push_back(cyc + 1);
            exe_adr.push_back(exe_addr_b);
         end
         if (exe_cyc.size() > 0 && t > 20) begin
            done = 1;
            break;
         end
      end
      if (!done) chk("B run timeout", 64'd1, 64'd0);
      chk("B write count", 64'(acc_addr.size()), 64'(LEN_B));
      for (int k = 0; k < int'(acc_addr.size()) && k < int'(LEN_B); k++)
         chk($sformatf("B byte %0d {addr,data,dl,cyc}", k),
             {7'd0, acc_addr[k], acc_data[k], acc_dl[k], acc_cyc[k]},
             {7'd0, 16'(k), rom_b[k], 1'b1, n_start + (LAT_B + 1) * 32'(k + 1)});
      chk("B execute count", 64'(exe_cyc.size()), 64'd1);
      if (exe_cyc.size() > 0)
         chk("B execute {cyc,addr}", 64'({exe_cyc[0], exe_adr[0]}),
             64'({n_start + (LAT_B + 1) * LEN_B + 1, EXEC_B}));
      chk("B idle after run", idle_word_b() & 64'h0000_0000_0003_FFFF, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      scen_t tbl [10];
      tbl[0] = '{K_PLAIN,       0,   S_NONE,   276, 1};
      tbl[1] = '{K_PLAIN,       0,   S_BYTE10, 276, 1};
      tbl[2] = '{K_ABORT,       100, S_NONE,   101, 0};
      tbl[3] = '{K_PLAIN,       0,   S_NONE,   276, 1};
      tbl[4] = '{K_RESET,       50,  S_NONE,   51,  0};
      tbl[5] = '{K_PLAIN,       0,   S_NONE,   276, 1};
      tbl[6] = '{K_RESTART,     20,  S_NONE,   276, 1};
      tbl[7] = '{K_PLAIN,       0,   S_RANDOM, 276, 1};
      tbl[8] = '{K_ABORT_IDLE,  -1,  S_NONE,   0,   0};
      tbl[9] = '{K_RESET_START, -1,  S_NONE,   0,   0};

      for (int i = 0; i < int'(LEN_A); i++) rom_a[i] = 8'($urandom);
      for (int i = 0; i < int'(LEN_B); i++) rom_b[i] = 8'($urandom);

      reset = 1'b1;
      start_a = 1'b0; abort_a = 1'b0; a_if.mem_wait = 1'b0;
      start_b = 1'b0; abort_b = 1'b0; b_if.mem_wait = 1'b0;
      repeat (3) @(negedge clk_sys);
      chk("A outputs in reset", idle_word_a(), 64'd0);
      chk("B outputs in reset", idle_word_b(), 64'd0);
      reset = 1'b0;
      @(negedge clk_sys);
      chk("A outputs idle after reset", idle_word_a(), 64'd0);

      for (int i = 0; i < 10; i++) run_a(i, tbl[i]);
      run_b();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/boot_loader_seq.md
Name: boot_loader_seq

Overview:
- Sequencer that copies the internal boot ROM image into PCW main memory after every reset, then fires a single execute request.
- Sits between the boot ROM (combinational/registered lookup) and the core's memory download port (dn_wr/dn_addr/dn_data with wait).
- Replaces the free-running inline copy loop with a handshaked, wait-aware state machine that can be aborted.

Parameters:
- ROM_LEN, 276, number of bytes copied (addresses 0..ROM_LEN-1).
- ROM_LAT, 1, boot ROM read latency in clk_sys cycles (1..3).
- EXEC_ADDR, 16'h0000, value driven on execute_addr with the execute pulse.

Ports:
- clk_sys  in  1  system clock (32 MHz); the only clock.
- reset  in  1  synchronous, active-high; overrides everything.
- start  in  1  one-cycle pulse (reset negedge detect); begins a copy when IDLE.
- abort  in  1  level; forces IDLE without an execute pulse (e.g. HPS ROM download).
- rom_addr  out  16  boot ROM read address.
- rom_data  in  8  boot ROM data, valid ROM_LAT cycles after rom_addr changes.
- mem_wr  out  1  write request to memory download port.
- mem_addr  out  16  write address.
- mem_data  out  8  write data.
- mem_wait  in  1  memory busy; a write is accepted on a cycle with mem_wr=1 and mem_wait=0.
- download  out  1  high while a copy is in progress.
- execute_enable  out  1  one-cycle pulse after the final byte is accepted.
- execute_addr  out  16  start address for the CPU, EXEC_ADDR while execute_enable=1, else 0.

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0. Reset mid-copy: abandon immediately, no execute pulse; reset with start in the same cycle: reset wins.
- States: IDLE, FETCH, WRITE, EXEC.
- IDLE: start=1 (and abort=0) -> counter=0, rom_addr=0, download=1, -> FETCH. start while not IDLE is ignored.
- FETCH: hold rom_addr=counter for ROM_LAT cycles (latency counter); on the last cycle, register rom_data into mem_data, mem_addr=counter -> WRITE.
- WRITE: mem_wr=1; mem_addr and mem_data are stable while mem_wait=1 (no timeout). On acceptance, if counter==ROM_LEN-1 -> EXEC, else counter+1, rom_addr=counter+1, mem_wr=0 -> FETCH.
- EXEC: one cycle: execute_enable=1, execute_addr=EXEC_ADDR, download=0, mem_wr=0 -> IDLE.
- abort=1 in any state other than IDLE -> IDLE next cycle: mem_wr=0, download=0, no execute pulse. An accept coincident with abort is still a completed write, but no further bytes are written. abort=1 while IDLE blocks start.
- Throughput: ROM_LAT+1 cycles per byte with mem_wait=0. With start sampled at edge N and ROM_LAT=1, byte k is written at N+2+2k, the last byte at N+552, and execute_enable at N+553.
- Counter is 16 bits and never wraps: termination is by equality to ROM_LEN-1. ROM_LEN=1 is legal: one byte, then execute.
- mem_wr is never asserted in two consecutive cycles for different addresses.

Decomposition:
- Package pcw_loader_pkg: state enum (IDLE, FETCH, WRITE, EXEC) and BOOT_ROM_LEN=276 constant, shared with the top-level and the boot_loader ROM.
- No sub-module. The start pulse comes from the existing edge_det instance at the top level.

Test Plan:
- Reset release, start pulse, mem_wait=0, ROM_LAT=1 -> 276 writes, addresses 0..275 with data equal to the ROM contents, execute_enable for exactly one cycle at start+553 with execute_addr=0, download low afterwards.
- mem_wait held high 5 cycles on byte 10 -> mem_wr, mem_addr=10 and data stable for all 5 cycles, a single accepted write, total completion delayed by exactly 5 cycles.
- abort asserted while writing byte 100 -> IDLE next cycle, no write to address 101, no execute pulse; a later start restarts from address 0.
- reset pulsed during byte 50 -> all outputs 0 the next cycle, no execute pulse; start after reset copies the full image.
- Second start pulse mid-copy at byte 20 -> ignored: address sequence continuous, exactly one execute pulse.
- ROM_LAT=3, ROM_LEN=4 -> 4 writes spaced 4 cycles apart, data matching the ROM despite latency, execute 1 cycle after the 4th accept.
